id_operand_stage: RTL

Decode-to-execute pipeline register for the RISC-V core. It sits directly downstream of the 2-read/1-write register file.
- Drives the register file read addresses from the decoded instruction.
- Resolves RAW hazards by forwarding from EX, MEM and WB, and stalls one cycle on load-use.
- Registers resolved operands and control into the EX stage with a valid/ready handshake and flush.

---
 rtl/id_operand_stage_if.sv | 64 ++++++
 rtl/id_operand_stage.sv | 125 ++++++++++++
 2 files changed

// File: rtl/id_operand_stage_if.sv
`timescale 1ns/1ps
// id_operand_stage_if
// Bundles the decode-side handshake, register-file read port, forwarding
// sources and EX-side handshake of the decode-to-execute operand stage.
//   master : environment (decoder, regfile, EX/MEM/WB, testbench)
//   slave  : id_operand_stage
interface id_operand_stage_if #(
  parameter int BITS       = 32,
  parameter int addr_width = 5,
  parameter int CTRL_BITS  = 16
);
  // decode side
  logic                  dec_valid;
  logic                  dec_ready;
  logic [addr_width-1:0] dec_rs1;
  logic [addr_width-1:0] dec_rs2;
  logic                  dec_use_rs1;
  logic                  dec_use_rs2;
  logic [addr_width-1:0] dec_rd;
  logic                  dec_rd_wen;
  logic                  dec_is_load;
  logic [CTRL_BITS-1:0]  dec_ctrl;
  // register file read port
  logic [addr_width-1:0] rf_a1;
  logic [addr_width-1:0] rf_a2;
  logic [BITS-1:0]       rf_q1;
  logic [BITS-1:0]       rf_q2;
  // forwarding sources
  logic [BITS-1:0]       ex_result;
  logic                  mem_fwd_wen;
  logic [addr_width-1:0] mem_fwd_rd;
  logic [BITS-1:0]       mem_fwd_data;
  logic                  wb_wen;
  logic [addr_width-1:0] wb_rd;
  logic [BITS-1:0]       wb_data;
  // EX side
  logic                  flush;
  logic                  ex_ready;
  logic                  ex_valid;
  logic [BITS-1:0]       ex_rs1_val;
  logic [BITS-1:0]       ex_rs2_val;
  logic [addr_width-1:0] ex_rd;
  logic                  ex_rd_wen;
  logic                  ex_is_load;
  logic [CTRL_BITS-1:0]  ex_ctrl;

  modport master (
    output dec_valid, dec_rs1, dec_rs2, dec_use_rs1, dec_use_rs2, dec_rd,
           dec_rd_wen, dec_is_load, dec_ctrl, rf_q1, rf_q2, ex_result,
           mem_fwd_wen, mem_fwd_rd, mem_fwd_data, wb_wen, wb_rd, wb_data,
           flush, ex_ready,
    input  dec_ready, rf_a1, rf_a2, ex_valid, ex_rs1_val, ex_rs2_val, ex_rd,
           ex_rd_wen, ex_is_load, ex_ctrl
  );

  modport slave (
    input  dec_valid, dec_rs1, dec_rs2, dec_use_rs1, dec_use_rs2, dec_rd,
           dec_rd_wen, dec_is_load, dec_ctrl, rf_q1, rf_q2, ex_result,
           mem_fwd_wen, mem_fwd_rd, mem_fwd_data, wb_wen, wb_rd, wb_data,
           flush, ex_ready,
    output dec_ready, rf_a1, rf_a2, ex_valid, ex_rs1_val, ex_rs2_val, ex_rd,
           ex_rd_wen, ex_is_load, ex_ctrl
  );
endinterface

// File: rtl/id_operand_stage.sv
`timescale 1ns/1ps
// id_operand_stage
// Decode-to-execute pipeline register. Drives the register file read
// addresses, resolves RAW hazards by forwarding from EX/MEM/WB, inserts a
// one-cycle bubble on load-use, and registers operands plus control into EX
// under a valid/ready handshake with flush.
// Ports:
//   clk   : rising-edge clock
//   reset : asynchronous active-high reset, clears every ex_* output
//   bus   : id_operand_stage_if.slave (decode, regfile, forwarding, EX)
module id_operand_stage #(
  parameter int BITS       = 32,
  parameter int addr_width = 5,
  parameter int CTRL_BITS  = 16
) (
  input logic             clk,
  input logic             reset,
  id_operand_stage_if.slave bus
);

  logic                  ex_valid_r;
  logic [BITS-1:0]       ex_rs1_val_r;
  logic [BITS-1:0]       ex_rs2_val_r;
  logic [addr_width-1:0] ex_rd_r;
  logic                  ex_rd_wen_r;
  logic                  ex_is_load_r;
  logic [CTRL_BITS-1:0]  ex_ctrl_r;

  logic                  ex_fwd_en_s;
  logic                  luse_s;
  logic                  dec_ready_s;
  logic                  accept_s;
  logic [BITS-1:0]       op1_s;
  logic [BITS-1:0]       op2_s;

  // Priority forwarding mux for one source: x0, EX, MEM, WB, then regfile.
  // x0 is caught first, so a producer targeting x0 never gets forwarded.
  function automatic logic [BITS-1:0] resolve_operand(
    input logic [addr_width-1:0] idx,
    input logic [BITS-1:0]       rf_q,
    input logic                  ex_en,
    input logic [addr_width-1:0] ex_rd,
    input logic [BITS-1:0]       ex_res,
    input logic                  mem_en,
    input logic [addr_width-1:0] mem_rd,
    input logic [BITS-1:0]       mem_data,
    input logic                  wb_en,
    input logic [addr_width-1:0] wb_rd,
    input logic [BITS-1:0]       wb_data
  );
    logic [BITS-1:0] val;
    if (idx == {addr_width{1'b0}}) begin
      val = {BITS{1'b0}};
    end else if (ex_en && (ex_rd == idx)) begin
      val = ex_res;
    end else if (mem_en && (mem_rd == idx)) begin
      val = mem_data;
    end else if (wb_en && (wb_rd == idx)) begin
      val = wb_data;
    end else begin
      val = rf_q;
    end
    return val;
  endfunction

  assign bus.rf_a1 = bus.dec_rs1;
  assign bus.rf_a2 = bus.dec_rs2;

  // Hazard detection, handshake and operand resolution.
  always_comb begin
    // A load in EX has no result yet, so it is not an EX forwarding source.
    ex_fwd_en_s = ex_valid_r & ex_rd_wen_r & ~ex_is_load_r;
    luse_s      = ex_valid_r & ex_is_load_r & ex_rd_wen_r &
                  (ex_rd_r != {addr_width{1'b0}}) &
                  ((bus.dec_use_rs1 & (ex_rd_r == bus.dec_rs1)) |
                   (bus.dec_use_rs2 & (ex_rd_r == bus.dec_rs2)));
    dec_ready_s = (~ex_valid_r | bus.ex_ready) & ~luse_s;
    accept_s    = bus.dec_valid & dec_ready_s;
    op1_s = resolve_operand(bus.dec_rs1, bus.rf_q1, ex_fwd_en_s, ex_rd_r,
                            bus.ex_result, bus.mem_fwd_wen, bus.mem_fwd_rd,
                            bus.mem_fwd_data, bus.wb_wen, bus.wb_rd, bus.wb_data);
    op2_s = resolve_operand(bus.dec_rs2, bus.rf_q2, ex_fwd_en_s, ex_rd_r,
                            bus.ex_result, bus.mem_fwd_wen, bus.mem_fwd_rd,
                            bus.mem_fwd_data, bus.wb_wen, bus.wb_rd, bus.wb_data);
  end

  assign bus.dec_ready = dec_ready_s;

  // EX pipeline register: flush beats accept beats drain; otherwise hold.
  // Payload only changes on accept, so held operands are never re-resolved.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ex_valid_r   <= 1'b0;
      ex_rs1_val_r <= {BITS{1'b0}};
      ex_rs2_val_r <= {BITS{1'b0}};
      ex_rd_r      <= {addr_width{1'b0}};
      ex_rd_wen_r  <= 1'b0;
      ex_is_load_r <= 1'b0;
      ex_ctrl_r    <= {CTRL_BITS{1'b0}};
    end else if (bus.flush) begin
      ex_valid_r <= 1'b0;
    end else if (accept_s) begin
      ex_valid_r   <= 1'b1;
      ex_rs1_val_r <= op1_s;
      ex_rs2_val_r <= op2_s;
      ex_rd_r      <= bus.dec_rd;
      ex_rd_wen_r  <= bus.dec_rd_wen;
      ex_is_load_r <= bus.dec_is_load;
      ex_ctrl_r    <= bus.dec_ctrl;
    end else if (bus.ex_ready && ex_valid_r) begin
      ex_valid_r <= 1'b0;
    end else begin
      ex_valid_r <= ex_valid_r;
    end
  end

  assign bus.ex_valid   = ex_valid_r;
  assign bus.ex_rs1_val = ex_rs1_val_r;
  assign bus.ex_rs2_val = ex_rs2_val_r;
  assign bus.ex_rd      = ex_rd_r;
  assign bus.ex_rd_wen  = ex_rd_wen_r;
  assign bus.ex_is_load = ex_is_load_r;
  assign bus.ex_ctrl    = ex_ctrl_r;

endmodule
